booth_pp_accumulator: RTL and testbench

- Sequential downstream consumer of the radix-4 Booth partial-product generator in the 32x32 multiplier path.
- Captures one full set of 17 partial products plus the 16 negate-correction bits under a valid/ready handshake.
- Sums them iteratively into a 64-bit product and presents the product under a valid/ready handshake.
- Low-area iterative alternative to a Wallace tree; one product every 19 cycles at full rate.

---
 rtl/booth_pp_accumulator.sv | 151 +++++++++++++++
 tb/tb_booth_pp_accumulator.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_pp_accumulator.sv
// Iterative summation of one radix-4 Booth partial-product set into a 64-bit product.
// Define BOOTH_ACC_DUAL_ADD_EN to fold two terms per accumulation edge (9 edges instead of 17).
module booth_pp_accumulator #(
    parameter int NUM_PP = 17
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] i,
    input  logic [33:0] pp0,
    input  logic [33:0] pp1,
    input  logic [33:0] pp2,
    input  logic [33:0] pp3,
    input  logic [33:0] pp4,
    input  logic [33:0] pp5,
    input  logic [33:0] pp6,
    input  logic [33:0] pp7,
    input  logic [33:0] pp8,
    input  logic [33:0] pp9,
    input  logic [33:0] pp10,
    input  logic [33:0] pp11,
    input  logic [33:0] pp12,
    input  logic [33:0] pp13,
    input  logic [33:0] pp14,
    input  logic [33:0] pp15,
    input  logic [31:0] pp16,
    input  logic        clear,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] product,
    output logic [1:0]  dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
    // in_ready and out_valid are registered and never depend on in_valid / out_ready.
    typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DONE = 2'd2} state_t;

    localparam logic [4:0] LAST = 5'(NUM_PP - 1);
`ifdef BOOTH_ACC_DUAL_ADD_EN
    localparam logic [4:0] CNT_INC = 5'd2;
`else
    localparam logic [4:0] CNT_INC = 5'd1;
`endif

    state_t      state;
    logic [4:0]  cnt;
    logic [63:0] acc;
    logic [33:0] pp_q [16];
    logic [31:0] pp16_q;
    logic [15:0] i_q;
    logic [33:0] pp_in [16];
    logic [63:0] term_a;
    logic [63:0] step;

    assign pp_in[0]  = pp0;
    assign pp_in[1]  = pp1;
    assign pp_in[2]  = pp2;
    assign pp_in[3]  = pp3;
    assign pp_in[4]  = pp4;
    assign pp_in[5]  = pp5;
    assign pp_in[6]  = pp6;
    assign pp_in[7]  = pp7;
    assign pp_in[8]  = pp8;
    assign pp_in[9]  = pp9;
    assign pp_in[10] = pp10;
    assign pp_in[11] = pp11;
    assign pp_in[12] = pp12;
    assign pp_in[13] = pp13;
    assign pp_in[14] = pp14;
    assign pp_in[15] = pp15;

    // Group k lands at weight 4^k; the unsigned-correction term sits at 2^32.
    function automatic logic [63:0] booth_term(input logic [4:0] idx, input logic [33:0] pp,
                                               input logic ib, input logic [31:0] p16);
        if (idx == 5'd16)
            return {p16, 32'd0};
        else
            return ({{30{pp[33]}}, pp} + 64'(ib)) << {idx[3:0], 1'b0};
    endfunction

`ifdef BOOTH_ACC_DUAL_ADD_EN
    logic [4:0]  cnt_b;
    logic [63:0] term_b;
    always_comb begin
        cnt_b  = cnt + 5'd1;
        term_a = booth_term(cnt, pp_q[cnt[3:0]], i_q[cnt[3:0]], pp16_q);
        term_b = booth_term(cnt_b, pp_q[cnt_b[3:0]], i_q[cnt_b[3:0]], pp16_q);
        step   = (cnt == LAST) ? term_a : term_a + term_b;
    end
`else
    always_comb begin
        term_a = booth_term(cnt, pp_q[cnt[3:0]], i_q[cnt[3:0]], pp16_q);
        step   = term_a;
    end
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= 5'd0;
            acc       <= 64'd0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            pp16_q    <= 32'd0;
            i_q       <= 16'd0;
            for (int k = 0; k < 16; k++) pp_q[k] <= 34'd0;
        end else if (clear) begin
            state     <= IDLE;
            cnt       <= 5'd0;
            acc       <= 64'd0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int k = 0; k < 16; k++) pp_q[k] <= pp_in[k];
                        pp16_q   <= pp16;
                        i_q      <= i;
                        acc      <= 64'd0;
                        cnt      <= 5'd0;
                        in_ready <= 1'b0;
                        state    <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc <= acc + step;
                    if (cnt == LAST) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + CNT_INC;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign product   = acc;
    assign dbg_state = state;

endmodule

// File: tb/tb_booth_pp_accumulator.sv
// Randomized self-checking bench for booth_pp_accumulator against arithmetic reference models.
module tb_booth_pp_accumulator;

`ifdef BOOTH_ACC_DUAL_ADD_EN
    localparam int LAT = 9;
`else
    localparam int LAT = 17;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] i_d;
    logic [33:0] pp_d [16];
    logic [31:0] pp16_d;
    logic        clear;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] product;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] exp_q[$];

    booth_pp_accumulator dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready), .i(i_d),
        .pp0(pp_d[0]), .pp1(pp_d[1]), .pp2(pp_d[2]), .pp3(pp_d[3]),
        .pp4(pp_d[4]), .pp5(pp_d[5]), .pp6(pp_d[6]), .pp7(pp_d[7]),
        .pp8(pp_d[8]), .pp9(pp_d[9]), .pp10(pp_d[10]), .pp11(pp_d[11]),
        .pp12(pp_d[12]), .pp13(pp_d[13]), .pp14(pp_d[14]), .pp15(pp_d[15]),
        .pp16(pp16_d), .clear(clear), .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .dbg_state(dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Upstream radix-4 Booth generator model: digit d_k in {-2..2}, negation as ~mag plus i[k].
    task automatic gen_booth(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        logic [33:0] a_ext, mag;
        logic [2:0]  g;
        int d;
        a_ext = sgn ? {{2{a[31]}}, a} : {2'b00, a};
        for (int k = 0; k < 16; k++) begin
            g = {b[2*k+1], b[2*k], (k == 0) ? 1'b0 : b[2*k-1]};
            d = -2 * int'(g[2]) + int'(g[1]) + int'(g[0]);
            if (d == 2 || d == -2) mag = a_ext << 1;
            else if (d == 0)       mag = 34'd0;
            else                   mag = a_ext;
            if (d < 0) begin
                pp_d[k] = ~mag;
                i_d[k]  = 1'b1;
            end else begin
                pp_d[k] = mag;
                i_d[k]  = 1'b0;
            end
        end
        pp16_d = (!sgn && b[31]) ? a : 32'd0;
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        if (sgn) return 64'(longint'($signed(a)) * longint'($signed(b)));
        else     return 64'(a) * 64'(b);
    endfunction

    // Weighted sum of whatever set is currently on the inputs.
    function automatic logic [63:0] ref_terms();
        longint s = 0;
        for (int k = 0; k < 16; k++)
            s += (longint'($signed(pp_d[k])) + longint'(i_d[k])) * (longint'(1) << (2 * k));
        s += longint'(pp16_d) * (longint'(1) << 32);
        return 64'(s);
    endfunction

    task automatic rand_raw();
        logic [63:0] r;
        for (int k = 0; k < 16; k++) begin
            r = {$urandom(), $urandom()};
            pp_d[k] = r[33:0];
        end
        i_d    = 16'($urandom());
        pp16_d = $urandom();
    endtask

    // Driver tasks: inputs change 1 time unit after a rising edge, outputs sampled there too.
    task automatic accept(input string tag);
        check_eq({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic take_output(input string tag, input int lat);
        logic [63:0] exp;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
        check_eq({tag, "_latency"}, 64'(lat), 64'(LAT));
        check_eq({tag, "_product"}, product, exp);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq({tag, "_out_valid_drop"}, 64'(out_valid), 64'd0);
    endtask

    task automatic run_txn(input string tag, input logic [63:0] exp, input int stall);
        int n;
        exp_q.push_back(exp);
        accept(tag);
        wait_valid(n);
        repeat (stall) begin
            @(posedge clk); #1;
        end
        take_output(tag, n);
    endtask

    initial begin
        logic [31:0] a, b;
        logic        sgn;
        logic [63:0] held;
        int          n, seen;

        resetn = 1'b0; in_valid = 1'b0; clear = 1'b0; out_ready = 1'b0;
        i_d = 16'd0; pp16_d = 32'd0;
        for (int k = 0; k < 16; k++) pp_d[k] = 34'd0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_product", product, 64'd0);
        resetn = 1'b1;
        @(posedge clk); #1;

        i_d = 16'hFFFF;
        run_txn("direct_i_only", 64'h0000_0000_5555_5555, 0);

        gen_booth(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_txn("umax", 64'hFFFF_FFFE_0000_0001, 0);
        gen_booth(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        run_txn("smin1", 64'h0000_0000_0000_0001, 1);
        gen_booth(32'h8000_0000, 32'h8000_0000, 1'b1);
        run_txn("sneg_sq", 64'h4000_0000_0000_0000, 0);
        gen_booth(32'h8000_0000, 32'd1, 1'b1);
        run_txn("sneg_x1", 64'hFFFF_FFFF_8000_0000, 2);

        for (int t = 0; t < 16; t++) begin
            a = $urandom(); b = $urandom(); sgn = 1'($urandom_range(0, 1));
            gen_booth(a, b, sgn);
            run_txn("rand_mul", ref_mul(a, b, sgn), $urandom_range(0, 3));
        end
        for (int t = 0; t < 8; t++) begin
            rand_raw();
            run_txn("rand_raw", ref_terms(), $urandom_range(0, 2));
        end

        // Backpressure, with stray in_valid pulses during ACCUM and DONE.
        gen_booth(32'd12345, 32'hFFFF_F000, 1'b1);
        exp_q.push_back(ref_mul(32'd12345, 32'hFFFF_F000, 1'b1));
        accept("bp");
        repeat (3) begin
            @(posedge clk); #1;
        end
        gen_booth(32'd99, 32'd99, 1'b0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid(n);
        n += 4;
        held = product;
        for (int c = 0; c < 5; c++) begin
            in_valid = (c == 2);
            @(posedge clk); #1;
            check_eq("bp_hold_product", product, held);
            check_eq("bp_hold_valid", 64'(out_valid), 64'd1);
            check_eq("bp_hold_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        take_output("bp", n);
        gen_booth(32'd7, 32'd6, 1'b0);
        run_txn("after_bp", 64'd42, 0);

        // Reset during accumulation: the in-flight result must vanish.
        rand_raw();
        accept("rst_mid");
        repeat (8) @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        check_eq("rst_mid_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_mid_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_mid_product", product, 64'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        seen = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check_eq("rst_mid_no_valid", 64'(seen), 64'd0);
        check_eq("rst_mid_in_ready_after", 64'(in_ready), 64'd1);

        // Clear in DONE together with out_ready: no transfer, accumulator zeroed.
        rand_raw();
        accept("clr_done");
        wait_valid(n);
        check_eq("clr_done_reached", 64'(out_valid), 64'd1);
        clear = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0; out_ready = 1'b0;
        check_eq("clr_done_out_valid", 64'(out_valid), 64'd0);
        check_eq("clr_done_in_ready", 64'(in_ready), 64'd1);
        check_eq("clr_done_product", product, 64'd0);

        // Clear during accumulation.
        rand_raw();
        accept("clr_acc");
        repeat (4) begin
            @(posedge clk); #1;
        end
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        check_eq("clr_acc_in_ready", 64'(in_ready), 64'd1);
        check_eq("clr_acc_product", product, 64'd0);

        a = $urandom(); b = $urandom();
        gen_booth(a, b, 1'b1);
        run_txn("after_clear", ref_mul(a, b, 1'b1), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
